// File: rtl/cnn_fixed_pkg.sv
// Shared Q8.8 fixed-point helpers and FSM state type for the classifier error path.
package cnn_fixed_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam logic signed [DATA_W-1:0] ONE_Q = 16'sd1 <<< FRAC_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_EMIT,
    ST_FINISH
  } fc_state_e;

  // Difference taken one bit wider so overflow is visible, then clamped to the Q8.8 range.
  function automatic logic signed [DATA_W-1:0] sat_sub(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W:0] diff;
    diff = {a[DATA_W-1], a} - {b[DATA_W-1], b};
    if (diff[DATA_W] != diff[DATA_W-1])
      sat_sub = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      sat_sub = diff[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] abs_mag(input logic signed [DATA_W-1:0] v);
    abs_mag = v[DATA_W-1] ? ((~v) + DATA_W'(1)) : v;
  endfunction

endpackage

// File: rtl/fc_argmax_tracker.sv
// Running argmax over scores presented one per update; ties keep the earliest index.
module fc_argmax_tracker
  import cnn_fixed_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     update,
  input  logic signed [DATA_W-1:0] value,
  input  logic [IDX_W-1:0]         idx,
  output logic [IDX_W-1:0]         max_idx
);

  logic signed [DATA_W-1:0] max_val;
  logic                     empty;

  // The first update of a sample is always taken, so no sentinel value is needed.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      max_val <= '0;
      max_idx <= '0;
      empty   <= 1'b1;
    end else if (update && (empty || value > max_val)) begin
      max_val <= value;
      max_idx <= idx;
      empty   <= 1'b0;
    end
  end

endmodule

// File: rtl/fc_error_gen.sv
// Classifier backward responder: gathers one sample's scores, streams score-minus-target
// errors to the FC backprop port, and keeps loss / prediction / accuracy statistics.
module fc_error_gen
  import cnn_fixed_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int LOSS_W      = 32,
  parameter int CNT_W       = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CLASSES-1:0]         label_onehot,
  input  logic                           label_valid,
  input  logic [DATA_W-1:0]              score_in,
  input  logic [$clog2(NUM_CLASSES)-1:0] score_idx,
  input  logic                           score_valid,
  output logic                           score_ready,
  output logic [DATA_W-1:0]              err_out,
  output logic [$clog2(NUM_CLASSES)-1:0] err_idx,
  output logic                           err_valid,
  input  logic                           err_ready,
  output logic                           sample_done,
  output logic [$clog2(NUM_CLASSES)-1:0] pred_class,
  output logic                           pred_correct,
  output logic [LOSS_W-1:0]              loss_acc,
  output logic [CNT_W-1:0]               sample_count,
  output logic [CNT_W-1:0]               correct_count,
  output logic                           label_error,
  input  logic                           clear_stats
);

  localparam int IDX_W = $clog2(NUM_CLASSES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  fc_state_e                state, state_nxt;
  logic [NUM_CLASSES-1:0]   label_q;
  logic [NUM_CLASSES-1:0]   mask;
  logic signed [DATA_W-1:0] score_buf [NUM_CLASSES];
  logic [IDX_W-1:0]         emit_idx;
  logic [IDX_W-1:0]         argmax_idx;
  logic signed [DATA_W-1:0] cur_score;
  logic signed [DATA_W-1:0] cur_err;
  logic [DATA_W-1:0]        cur_mag;
  logic [LOSS_W:0]          loss_sum;
  logic                     start, score_xfer, idx_bad, err_xfer;

  assign start      = (state == ST_IDLE) && label_valid;
  assign score_xfer = (state == ST_COLLECT) && score_valid;
  assign idx_bad    = score_idx > LAST_IDX;
  assign err_xfer   = (state == ST_EMIT) && err_ready;
  assign cur_score  = score_buf[emit_idx];
  assign cur_err    = sat_sub(cur_score, label_q[emit_idx] ? ONE_Q : {DATA_W{1'b0}});
  assign cur_mag    = abs_mag(cur_err);
  assign loss_sum   = {1'b0, loss_acc} + {{(LOSS_W - DATA_W + 1){1'b0}}, cur_mag};
  assign err_idx    = emit_idx;

  always_comb begin
    state_nxt   = state;
    score_ready = 1'b0;
    err_valid   = 1'b0;
    err_out     = '0;
    sample_done = 1'b0;
    case (state)
      ST_IDLE:    if (label_valid) state_nxt = ST_COLLECT;
      ST_COLLECT: begin
        score_ready = 1'b1;
        if (&mask) state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        err_valid = 1'b1;
        err_out   = cur_err;
        if (err_ready && emit_idx == LAST_IDX) state_nxt = ST_FINISH;
      end
      ST_FINISH: begin
        sample_done = 1'b1;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Score storage needs no reset: every entry is rewritten before a sample can reach EMIT.
  always_ff @(posedge clk) begin
    if (score_xfer && !idx_bad) score_buf[score_idx] <= score_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      label_q       <= '0;
      mask          <= '0;
      emit_idx      <= '0;
      pred_class    <= '0;
      pred_correct  <= 1'b0;
      loss_acc      <= '0;
      sample_count  <= '0;
      correct_count <= '0;
      label_error   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        label_q  <= label_onehot;
        mask     <= '0;
        emit_idx <= '0;
      end
      if (score_xfer) begin
        if (idx_bad) label_error <= 1'b1;
        else         mask[score_idx] <= 1'b1;
      end
      if (err_xfer) begin
        emit_idx <= (emit_idx == LAST_IDX) ? '0 : emit_idx + 1'b1;
        loss_acc <= loss_sum[LOSS_W] ? {LOSS_W{1'b1}} : loss_sum[LOSS_W-1:0];
      end
      if (state == ST_FINISH) begin
        pred_class    <= argmax_idx;
        pred_correct  <= label_q[argmax_idx];
        sample_count  <= sample_count + 1'b1;
        correct_count <= correct_count + CNT_W'(label_q[argmax_idx]);
        if (label_q == '0) label_error <= 1'b1;
      end
      // Placed last so a clear coinciding with FINISH overrides the statistic updates.
      if (clear_stats) begin
        loss_acc      <= '0;
        sample_count  <= '0;
        correct_count <= '0;
        label_error   <= 1'b0;
      end
    end
  end

  fc_argmax_tracker #(
    .IDX_W (IDX_W)
  ) u_argmax (
    .clk     (clk),
    .reset   (reset),
    .clear   (start),
    .update  (err_xfer),
    .value   (cur_score),
    .idx     (emit_idx),
    .max_idx (argmax_idx)
  );

endmodule

// File: tb/tb_fc_error_gen.sv
// Directed bench for fc_error_gen: per-scenario tasks with hand-computed expectations.
module tb_fc_error_gen;
  import cnn_fixed_pkg::*;

  localparam int NC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  label_onehot;
  logic        label_valid;
  logic [15:0] score_in;
  logic [3:0]  score_idx;
  logic        score_valid;
  logic        score_ready;
  logic [15:0] err_out;
  logic [3:0]  err_idx;
  logic        err_valid;
  logic        err_ready;
  logic        sample_done;
  logic [3:0]  pred_class;
  logic        pred_correct;
  logic [31:0] loss_acc;
  logic [15:0] sample_count;
  logic [15:0] correct_count;
  logic        label_error;
  logic        clear_stats;

  int          total = 0;
  int          bad = 0;
  logic [15:0] errs [NC];
  logic [3:0]  idxs [NC];
  logic [15:0] exp_err [NC];
  int          n_xfer, n_done;
  bit          stable_ok;

  always #5 clk = ~clk;

  fc_error_gen dut (
    .clk           (clk),
    .reset         (reset),
    .label_onehot  (label_onehot),
    .label_valid   (label_valid),
    .score_in      (score_in),
    .score_idx     (score_idx),
    .score_valid   (score_valid),
    .score_ready   (score_ready),
    .err_out       (err_out),
    .err_idx       (err_idx),
    .err_valid     (err_valid),
    .err_ready     (err_ready),
    .sample_done   (sample_done),
    .pred_class    (pred_class),
    .pred_correct  (pred_correct),
    .loss_acc      (loss_acc),
    .sample_count  (sample_count),
    .correct_count (correct_count),
    .label_error   (label_error),
    .clear_stats   (clear_stats)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_label(input logic [9:0] lab);
    label_onehot = lab;
    label_valid  = 1'b1;
    tick();
    label_valid  = 1'b0;
  endtask

  task automatic send_score(input logic [3:0] idx, input logic [15:0] val);
    score_valid = 1'b1;
    score_idx   = idx;
    score_in    = val;
    tick();
    score_valid = 1'b0;
  endtask

  // Drains one sample's errors; records transfers, done pulses and stall stability.
  task automatic run_emit(input bit stall, input bit clr_at_done);
    int          cyc;
    bit          held;
    logic [15:0] held_err;
    logic [3:0]  held_idx;
    n_xfer = 0; n_done = 0; stable_ok = 1'b1; held = 1'b0; cyc = 0;
    held_err = '0; held_idx = '0;
    for (int i = 0; i < NC; i++) begin errs[i] = 'x; idxs[i] = 'x; end
    while ((n_xfer < NC || n_done == 0) && cyc < 80) begin
      clear_stats = 1'b0;
      err_ready   = stall ? ~cyc[0] : 1'b1;
      if (held && err_valid && (err_out !== held_err || err_idx !== held_idx)) stable_ok = 1'b0;
      if (sample_done) begin
        n_done++;
        if (clr_at_done) clear_stats = 1'b1;
      end
      if (err_valid && err_ready) begin
        if (n_xfer < NC) begin errs[n_xfer] = err_out; idxs[n_xfer] = err_idx; end
        n_xfer++;
        held = 1'b0;
      end else if (err_valid) begin
        held = 1'b1; held_err = err_out; held_idx = err_idx;
      end
      tick();
      cyc++;
    end
    err_ready   = 1'b0;
    clear_stats = 1'b0;
  endtask

  task automatic check_errs(input string name);
    total++;
    if (n_xfer !== NC) begin bad++; $display("[TB] FAIL %s_xfers got=%0d want=%0d", name, n_xfer, NC); end
    for (int i = 0; i < NC; i++) begin
      total++;
      if (errs[i] !== exp_err[i] || idxs[i] !== 4'(i)) begin
        bad++;
        $display("[TB] FAIL %s_err[%0d] got err=%h idx=%0d want err=%h idx=%0d", name, i, errs[i], idxs[i], exp_err[i], i);
      end
    end
  endtask

  task automatic check_stats(input string name, input logic [3:0] pc, input logic pok,
                             input logic [31:0] loss, input logic [15:0] sc, input logic [15:0] cc, input logic le);
    total++;
    if ({pred_class, pred_correct, loss_acc, sample_count, correct_count, label_error} !== {pc, pok, loss, sc, cc, le}) begin
      bad++;
      $display("[TB] FAIL %s_stats got pred=%0d ok=%0d loss=%h smp=%0d cor=%0d lerr=%0d want pred=%0d ok=%0d loss=%h smp=%0d cor=%0d lerr=%0d",
               name, pred_class, pred_correct, loss_acc, sample_count, correct_count, label_error, pc, pok, loss, sc, cc, le);
    end
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({score_ready, err_out, err_idx, err_valid, sample_done, pred_class, pred_correct,
         loss_acc, sample_count, correct_count, label_error} !== '0) begin
      bad++;
      $display("[TB] FAIL %s got rdy=%0d err=%h idx=%0d ev=%0d done=%0d pred=%0d ok=%0d loss=%h smp=%0d cor=%0d lerr=%0d want all zero",
               name, score_ready, err_out, err_idx, err_valid, sample_done, pred_class, pred_correct,
               loss_acc, sample_count, correct_count, label_error);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    check_all_zero("reset");
  endtask

  task automatic test_basic();
    send_label(10'h004);
    total++;
    if (score_ready !== 1'b1) begin bad++; $display("[TB] FAIL basic_ready got=%0d want=1", score_ready); end
    for (int i = 0; i < NC; i++) send_score(4'(i), (i == 2) ? 16'h0180 : 16'h0000);
    total++;
    if (err_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_latency got=%0d want=0", err_valid); end
    run_emit(1'b0, 1'b0);
    for (int i = 0; i < NC; i++) exp_err[i] = (i == 2) ? 16'h0080 : 16'h0000;
    check_errs("basic");
    check_stats("basic", 4'd2, 1'b1, 32'h0000_0080, 16'd1, 16'd1, 1'b0);
  endtask

  task automatic test_saturation();
    send_label(10'h001);
    for (int i = 0; i < NC; i++) send_score(4'(i), (i == 0) ? 16'h8000 : 16'h0000);
    run_emit(1'b0, 1'b0);
    for (int i = 0; i < NC; i++) exp_err[i] = (i == 0) ? 16'h8000 : 16'h0000;
    check_errs("sat");
    check_stats("sat", 4'd1, 1'b0, 32'h0000_8080, 16'd2, 16'd1, 1'b0);
  endtask

  task automatic test_reverse_dup();
    int ord [11] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 5, 0};
    send_label(10'h020);
    for (int k = 0; k < 11; k++)
      send_score(4'(ord[k]), (k == 9) ? 16'h0200 : 16'(ord[k] * 16));
    run_emit(1'b0, 1'b0);
    for (int i = 0; i < NC; i++) exp_err[i] = (i == 5) ? 16'h0100 : 16'(i * 16);
    check_errs("revdup");
    total++;
    if (n_done !== 1 || sample_done !== 1'b0) begin
      bad++; $display("[TB] FAIL revdup_done got pulses=%0d now=%0d want pulses=1 now=0", n_done, sample_done);
    end
    check_stats("revdup", 4'd5, 1'b1, 32'h0000_8400, 16'd3, 16'd2, 1'b0);
  endtask

  task automatic test_back_to_back_stall();
    send_label(10'h004);
    for (int i = 0; i < NC; i++) send_score(4'(i), (i == 2) ? 16'h0180 : 16'h0000);
    run_emit(1'b1, 1'b0);
    for (int i = 0; i < NC; i++) exp_err[i] = (i == 2) ? 16'h0080 : 16'h0000;
    check_errs("stall");
    total++;
    if (stable_ok !== 1'b1) begin bad++; $display("[TB] FAIL stall_hold got=unstable want=stable"); end
    check_stats("stall", 4'd2, 1'b1, 32'h0000_8480, 16'd4, 16'd3, 1'b0);
  endtask

  task automatic test_tie_zero_hot();
    send_label(10'h008);
    for (int i = 0; i < NC; i++) send_score(4'(i), (i == 3 || i == 7) ? 16'h0100 : 16'h0000);
    run_emit(1'b0, 1'b0);
    for (int i = 0; i < NC; i++) exp_err[i] = (i == 7) ? 16'h0100 : 16'h0000;
    check_errs("tie");
    check_stats("tie", 4'd3, 1'b1, 32'h0000_8580, 16'd5, 16'd4, 1'b0);
    send_label(10'h000);
    for (int i = 0; i < NC; i++) send_score(4'(i), (i == 3 || i == 7) ? 16'h0100 : 16'h0000);
    run_emit(1'b0, 1'b0);
    for (int i = 0; i < NC; i++) exp_err[i] = (i == 3 || i == 7) ? 16'h0100 : 16'h0000;
    check_errs("zerohot");
    check_stats("zerohot", 4'd3, 1'b0, 32'h0000_8780, 16'd6, 16'd4, 1'b1);
  endtask

  task automatic test_reset_clear();
    send_label(10'h004);
    for (int i = 0; i < NC; i++) send_score(4'(i), (i == 2) ? 16'h0180 : 16'h0000);
    err_ready = 1'b1;
    tick();
    tick();
    tick();
    total++;
    if (err_valid !== 1'b1 || err_idx !== 4'd2) begin
      bad++; $display("[TB] FAIL midemit got ev=%0d idx=%0d want ev=1 idx=2", err_valid, err_idx);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    err_ready = 1'b0;
    check_all_zero("reset_mid");
    send_label(10'h010);
    send_score(4'd12, 16'h7777);
    total++;
    if (label_error !== 1'b1) begin bad++; $display("[TB] FAIL badidx_lerr got=%0d want=1", label_error); end
    for (int i = 0; i < NC; i++) send_score(4'(i), (i == 4) ? 16'h0300 : 16'h0000);
    run_emit(1'b0, 1'b1);
    for (int i = 0; i < NC; i++) exp_err[i] = (i == 4) ? 16'h0200 : 16'h0000;
    check_errs("clear");
    check_stats("clear", 4'd4, 1'b1, 32'h0000_0000, 16'd0, 16'd0, 1'b0);
  endtask

  initial begin
    reset        = 1'b0;
    label_onehot = '0;
    label_valid  = 1'b0;
    score_in     = '0;
    score_idx    = '0;
    score_valid  = 1'b0;
    err_ready    = 1'b0;
    clear_stats  = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_reverse_dup();
    test_back_to_back_stall();
    test_tie_zero_hot();
    test_reset_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fc_error_gen.md
Name: fc_error_gen

Overview:
- Backward-direction responder at the classifier output of the CNN training datapath.
- Collects one sample's NUM_CLASSES fully-connected output scores (Q8.8) and latches the one-hot label.
- Streams the per-class error (score − target) back to the fully-connected layer's backprop port.
- Keeps running loss, argmax prediction and accuracy counters, replacing bench-side error arithmetic with RTL.

Parameters:
NUM_CLASSES, 10, number of classifier outputs
DATA_W, 16, score/error width, signed two's complement
FRAC_W, 8, fractional bits (Q8.8; 1.0 = 0x0100)
LOSS_W, 32, loss accumulator width
CNT_W, 16, sample/correct counter width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low
label_onehot  in  NUM_CLASSES  one-hot true label
label_valid  in  1  label present; sampled only in IDLE
score_in  in  DATA_W  FC output score
score_idx  in  $clog2(NUM_CLASSES)  class index of score_in
score_valid  in  1  score handshake valid
score_ready  out  1  high only in COLLECT
err_out  out  DATA_W  saturated score − target
err_idx  out  $clog2(NUM_CLASSES)  class index of err_out
err_valid  out  1  error handshake valid
err_ready  in  1  backprop consumer ready
sample_done  out  1  one-cycle pulse at end of sample
pred_class  out  $clog2(NUM_CLASSES)  argmax of last sample
pred_correct  out  1  last prediction matched label
loss_acc  out  LOSS_W  sum of |err|, saturating
sample_count  out  CNT_W  samples completed, wrapping
correct_count  out  CNT_W  correct predictions, wrapping
label_error  out  1  sticky: zero-hot label or out-of-range score_idx
clear_stats  in  1  zero loss_acc/sample_count/correct_count/label_error

Behaviour:
- Reset (reset==0 at posedge): state IDLE; every output 0; received mask cleared. Reset mid-sample aborts it with no counter update.
- States: IDLE → COLLECT → EMIT → FINISH → IDLE.
- IDLE: score_ready=0. label_valid=1 latches label_onehot, clears received mask, → COLLECT next cycle.
- COLLECT: score_ready=1. Transfer on score_valid & score_ready: store score at score_idx, set mask bit.
  - Duplicate index overwrites the stored score.
  - score_idx ≥ NUM_CLASSES: transfer discarded, label_error set.
  - When all mask bits are set (after the final transfer's edge) → EMIT; err_valid high on EMIT's first cycle.
- EMIT: index i from 0 to NUM_CLASSES−1. err_out = sat(score[i] − target), target = 0x0100 if label bit i else 0.
  - Subtract at DATA_W+1 bits, then clamp to [0x8000, 0x7FFF].
  - err_out/err_idx/err_valid held stable until err_ready. One error per cycle when err_ready stays high.
  - On each transfer: loss_acc += |err| (|0x8000| = 32768), saturating at all-ones.
  - Argmax: strict greater-than scan, so ties resolve to the lowest index.
  - Transfer of index NUM_CLASSES−1 → FINISH.
- FINISH: one cycle.
  - sample_done=1; pred_class and pred_correct updated (pred_correct = label bit at argmax).
  - sample_count+1; correct_count+1 if pred_correct.
  - Zero-hot label: label_error set, pred_correct=0.
  - → IDLE.
- clear_stats: one-cycle synchronous clear in any state. If asserted in FINISH, the clear wins for the counters, loss_acc and label_error; pred_class/pred_correct still update.
- Latency: last score accepted at edge N → err_valid visible after edge N+1. Minimum sample length NUM_CLASSES + NUM_CLASSES + 3 cycles.

Decomposition:
- Package cnn_fixed_pkg: DATA_W, FRAC_W, ONE_Q (0x0100), a saturating-subtract function, an abs function.
- One sub-module: fc_argmax_tracker (registered running max value/index, cleared on COLLECT entry, updated per EMIT transfer).
- Score buffer and FSM stay in fc_error_gen.

Test Plan:
- Label 0x004 (class 2); scores idx0..9 = 0x0000 except idx2=0x0180 → errors all 0 except idx2=0x0080; pred_class=2, pred_correct=1, loss_acc=0x80, correct_count=1.
- Label class 0; score idx0=0x8000 → err_out=0x8000 saturated; loss_acc += 32768; pred_class ≠ 0, pred_correct=0.
- Scores delivered in reverse order plus one duplicate idx5 (second value 0x0200) → EMIT order 0..9; err_idx5 uses 0x0200; sample_done once.
- err_ready toggled 1/0 every cycle during EMIT → err_out/err_idx stable while stalled; exactly 10 transfers; loss identical to the no-stall run.
- Ties: scores idx3 = idx7 = 0x0100, rest 0 → pred_class=3. Zero-hot label → label_error=1, pred_correct=0.
- Reset low mid-EMIT, then clear_stats coincident with FINISH → all outputs 0 after reset; counters 0 after FINISH; pred_class still updated.
